// File: rtl/sysctl_pkg.sv
// sysctl_pkg -- shared definitions for the system-control block.
//   state_t        : controller FSM encoding
//   DEF_*          : default version and command/response code constants
//   WORD_BITS      : width of one argument / response word
package sysctl_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        VER,
        SYNC_ARGS,
        SYNC_APPLY,
        TIME,
        WAIT_GRANT,
        SHUT,
        DONE
    } state_t;

    localparam logic [31:0] DEF_VERSION         = 32'd0;
    localparam int          DEF_CMD_GET_VERSION = 0;
    localparam logic [31:0] DEF_RSP_GET_VERSION = 32'd0;
    localparam int          DEF_CMD_SYNC_TIME   = 0;
    localparam logic [31:0] DEF_RSP_SYNC_TIME   = 32'd0;
    localparam int          DEF_CMD_GET_TIME    = 0;
    localparam logic [31:0] DEF_RSP_GET_TIME    = 32'd0;
    localparam int          DEF_CMD_SHUTDOWN    = 0;
    localparam logic [31:0] DEF_RSP_SHUTDOWN    = 32'd0;

endpackage

// File: rtl/sysctl_sync.sv
// sync_edge -- two-flop synchronizer followed by a single-cycle edge detector.
//   clk, rst : clock, synchronous active-high reset
//   d        : asynchronous input
//   pulse    : one-cycle strobe on the selected edge of the synchronized input
//              (FALLING=1 -> 1->0 transition, FALLING=0 -> 0->1 transition)
module sync_edge #(
    parameter bit FALLING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    // sr[0], sr[1]: synchronizer stages; sr[2]: previous synchronized value
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], d};
    end

    assign pulse = FALLING ? (sr[2] & ~sr[1]) : (sr[1] & ~sr[2]);

endmodule

// File: rtl/sysctl.sv
// sysctl -- command-driven system controller: version/feature query, time read,
// latch-compensated time synchronization and sticky shutdown with an
// involuntary fault report path.
//   clk, rst                   : clock, synchronous active-high reset
//   cmd, cmd_ready             : command code and valid (accepted only in IDLE)
//   arg_data, arg_advance      : argument word and consume strobe
//   param_data, param_write    : response words; cmd_done marks the final code
//   invol_req, invol_grant     : slot handshake for the unsolicited fault report
//   time_in / time_out(_en)    : current time / new time load
//   timesync_latch_in          : asynchronous sync pulse
//   shutdown_src / shutdown / shutdown_reason : fault inputs, sticky state, cause
module sysctl
    import sysctl_pkg::*;
#(
    parameter int                    CMD_BITS        = 8,
    parameter int                    TIME_BITS       = 64,
    parameter int                    NCFG            = 2,
    parameter logic [NCFG*32-1:0]    CFG_WORDS       = '0,
    parameter int                    NSRC            = 8,
    parameter int                    SYNC_COMP       = 4,
    parameter int                    LATCH_FALLING   = 1,
    parameter logic [31:0]           VERSION         = DEF_VERSION,
    parameter logic [CMD_BITS-1:0]   CMD_GET_VERSION = CMD_BITS'(DEF_CMD_GET_VERSION),
    parameter logic [31:0]           RSP_GET_VERSION = DEF_RSP_GET_VERSION,
    parameter logic [CMD_BITS-1:0]   CMD_SYNC_TIME   = CMD_BITS'(DEF_CMD_SYNC_TIME),
    parameter logic [31:0]           RSP_SYNC_TIME   = DEF_RSP_SYNC_TIME,
    parameter logic [CMD_BITS-1:0]   CMD_GET_TIME    = CMD_BITS'(DEF_CMD_GET_TIME),
    parameter logic [31:0]           RSP_GET_TIME    = DEF_RSP_GET_TIME,
    parameter logic [CMD_BITS-1:0]   CMD_SHUTDOWN    = CMD_BITS'(DEF_CMD_SHUTDOWN),
    parameter logic [31:0]           RSP_SHUTDOWN    = DEF_RSP_SHUTDOWN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 cmd_ready,
    input  logic [31:0]          arg_data,
    output logic                 arg_advance,
    output logic                 cmd_done,
    output logic [31:0]          param_data,
    output logic                 param_write,
    output logic                 invol_req,
    input  logic                 invol_grant,
    input  logic [TIME_BITS-1:0] time_in,
    output logic [TIME_BITS-1:0] time_out,
    output logic                 time_out_en,
    input  logic                 timesync_latch_in,
    input  logic [NSRC-1:0]      shutdown_src,
    output logic                 shutdown,
    output logic [NSRC-1:0]      shutdown_reason
);

    localparam int NTW = TIME_BITS / 32;

    state_t                state;
    logic [7:0]            cnt;
    logic [31:0]           rsp_code;
    logic [NCFG*32-1:0]    cfg_sh;     // feature words, shifted out low word first
    logic [TIME_BITS-1:0]  time_sh;    // GET_TIME snapshot, shifted out low word first
    logic [TIME_BITS-1:0]  args;       // SYNC_TIME argument, shifted in from the top
    logic [TIME_BITS-1:0]  latched_time;
    logic                  latch_valid;
    logic                  latch_pulse;

    sync_edge #(
        .FALLING (LATCH_FALLING != 0)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (timesync_latch_in),
        .pulse (latch_pulse)
    );

    // NOTE: every register in this block uses <= so all reads see the values
    // from before the edge; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath holding registers are cleared too, so nothing
            // from an interrupted transaction can surface after reset.
            state           <= IDLE;
            cnt             <= '0;
            rsp_code        <= '0;
            cfg_sh          <= '0;
            time_sh         <= '0;
            args            <= '0;
            latched_time    <= '0;
            latch_valid     <= 1'b0;
            arg_advance     <= 1'b0;
            cmd_done        <= 1'b0;
            param_data      <= '0;
            param_write     <= 1'b0;
            invol_req       <= 1'b0;
            time_out        <= '0;
            time_out_en     <= 1'b0;
            shutdown        <= 1'b0;
            shutdown_reason <= '0;
        end else begin
            cmd_done    <= 1'b0;
            param_write <= 1'b0;
            param_data  <= '0;
            time_out_en <= 1'b0;

            // A latch edge always wins over the clear in SYNC_APPLY, so an edge
            // arriving during the apply cycle is kept for the next sync.
            if (latch_pulse) begin
                latched_time <= time_in;
                latch_valid  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_ready) begin
                        if (cmd == CMD_GET_VERSION) begin
                            param_data  <= VERSION;
                            param_write <= 1'b1;
                            cfg_sh      <= CFG_WORDS;
                            cnt         <= '0;
                            rsp_code    <= RSP_GET_VERSION;
                            state       <= VER;
                        end else if (cmd == CMD_SYNC_TIME) begin
                            arg_advance <= 1'b1;
                            cnt         <= '0;
                            rsp_code    <= RSP_SYNC_TIME;
                            state       <= SYNC_ARGS;
                        end else if (cmd == CMD_GET_TIME) begin
                            param_data  <= time_in[31:0];
                            param_write <= 1'b1;
                            time_sh     <= time_in >> 32;
                            cnt         <= '0;
                            rsp_code    <= RSP_GET_TIME;
                            state       <= (NTW == 1) ? DONE : TIME;
                        end else if (cmd == CMD_SHUTDOWN) begin
                            shutdown    <= 1'b1;
                            cmd_done    <= 1'b1;
                            param_data  <= RSP_SHUTDOWN;
                        end else begin
                            cmd_done    <= 1'b1;
                        end
                    end else if (!shutdown && |shutdown_src) begin
                        invol_req <= 1'b1;
                        state     <= WAIT_GRANT;
                    end
                end

                VER: begin
                    param_data  <= cfg_sh[31:0];
                    param_write <= 1'b1;
                    cfg_sh      <= cfg_sh >> 32;
                    cnt         <= cnt + 8'd1;
                    if (cnt == 8'(NCFG - 1)) state <= DONE;
                end

                TIME: begin
                    param_data  <= time_sh[31:0];
                    param_write <= 1'b1;
                    time_sh     <= time_sh >> 32;
                    cnt         <= cnt + 8'd1;
                    if (cnt == 8'(NTW - 2)) state <= DONE;
                end

                SYNC_ARGS: begin
                    args <= (args >> 32) | (TIME_BITS'(arg_data) << (TIME_BITS - 32));
                    cnt  <= cnt + 8'd1;
                    if (cnt == 8'(NTW - 1)) begin
                        arg_advance <= 1'b0;
                        state       <= SYNC_APPLY;
                    end
                end

                SYNC_APPLY: begin
                    param_write <= 1'b1;
                    if (latch_valid) begin
                        time_out    <= time_in - latched_time + args + TIME_BITS'(SYNC_COMP);
                        time_out_en <= 1'b1;
                        param_data  <= 32'd1;
                        if (!latch_pulse) latch_valid <= 1'b0;
                    end
                    state <= DONE;
                end

                WAIT_GRANT: begin
                    if (invol_grant) begin
                        invol_req       <= 1'b0;
                        shutdown_reason <= shutdown_src;
                        param_data      <= 32'(shutdown_src);
                        param_write     <= 1'b1;
                        state           <= SHUT;
                    end
                end

                SHUT: begin
                    shutdown   <= 1'b1;
                    cmd_done   <= 1'b1;
                    param_data <= RSP_SHUTDOWN;
                    state      <= IDLE;
                end

                DONE: begin
                    cmd_done   <= 1'b1;
                    param_data <= rsp_code;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysctl.sv
module tb_sysctl;

    localparam logic [7:0]  C_VER  = 8'h01;
    localparam logic [7:0]  C_SYNC = 8'h02;
    localparam logic [7:0]  C_TIME = 8'h03;
    localparam logic [7:0]  C_SHUT = 8'h04;
    localparam logic [31:0] R_VER  = 32'h81;
    localparam logic [31:0] R_SYNC = 32'h82;
    localparam logic [31:0] R_TIME = 32'h83;
    localparam logic [31:0] R_SHUT = 32'h84;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic [31:0] arg_data;
    logic        arg_advance;
    logic        cmd_done;
    logic [31:0] param_data;
    logic        param_write;
    logic        invol_req;
    logic        invol_grant;
    logic [63:0] time_in;
    logic [63:0] time_out;
    logic        time_out_en;
    logic        timesync_latch_in;
    logic [7:0]  shutdown_src;
    logic        shutdown;
    logic [7:0]  shutdown_reason;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sysctl #(
        .CMD_BITS(8), .TIME_BITS(64), .NCFG(2), .CFG_WORDS({32'hB, 32'hA}),
        .NSRC(8), .SYNC_COMP(4), .LATCH_FALLING(1), .VERSION(32'd3),
        .CMD_GET_VERSION(C_VER), .RSP_GET_VERSION(R_VER),
        .CMD_SYNC_TIME(C_SYNC), .RSP_SYNC_TIME(R_SYNC),
        .CMD_GET_TIME(C_TIME), .RSP_GET_TIME(R_TIME),
        .CMD_SHUTDOWN(C_SHUT), .RSP_SHUTDOWN(R_SHUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_ready(cmd_ready),
        .arg_data(arg_data), .arg_advance(arg_advance), .cmd_done(cmd_done),
        .param_data(param_data), .param_write(param_write),
        .invol_req(invol_req), .invol_grant(invol_grant),
        .time_in(time_in), .time_out(time_out), .time_out_en(time_out_en),
        .timesync_latch_in(timesync_latch_in), .shutdown_src(shutdown_src),
        .shutdown(shutdown), .shutdown_reason(shutdown_reason)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] code);
        cmd       = code;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic word(input string tag, input logic [31:0] exp);
        check({tag, "_wr"}, {63'd0, param_write}, 64'd1);
        check({tag, "_data"}, {32'd0, param_data}, {32'd0, exp});
        check({tag, "_nodone"}, {63'd0, cmd_done}, 64'd0);
    endtask

    task automatic done(input string tag, input logic [31:0] exp);
        check({tag, "_done"}, {63'd0, cmd_done}, 64'd1);
        check({tag, "_wr0"}, {63'd0, param_write}, 64'd0);
        check({tag, "_rsp"}, {32'd0, param_data}, {32'd0, exp});
    endtask

    task automatic get_version(input string tag);
        issue(C_VER);
        word({tag, "_w0"}, 32'd3);
        tick(); word({tag, "_w1"}, 32'hA);
        tick(); word({tag, "_w2"}, 32'hB);
        tick(); done(tag, R_VER);
        tick();
        check({tag, "_after"}, {63'd0, cmd_done}, 64'd0);
    endtask

    // SYNC_TIME with 64-bit argument; apply_time is time_in in the apply cycle
    task automatic sync_time(input string tag, input logic [63:0] arg,
                             input logic [63:0] apply_time, input bit exp_applied,
                             input logic [63:0] exp_time);
        int en_cnt = 0;
        issue(C_SYNC);
        check({tag, "_adv0"}, {63'd0, arg_advance}, 64'd1);
        arg_data = arg[31:0];
        tick();
        check({tag, "_adv1"}, {63'd0, arg_advance}, 64'd1);
        arg_data = arg[63:32];
        tick();
        check({tag, "_adv_off"}, {63'd0, arg_advance}, 64'd0);
        time_in = apply_time;
        tick();
        if (time_out_en) en_cnt++;
        word({tag, "_status"}, {31'd0, exp_applied});
        if (exp_applied) check({tag, "_time_out"}, time_out, exp_time);
        tick();
        if (time_out_en) en_cnt++;
        done(tag, R_SYNC);
        tick();
        if (time_out_en) en_cnt++;
        check({tag, "_en_pulses"}, 64'(en_cnt), exp_applied ? 64'd1 : 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd = '0; cmd_ready = 1'b0; arg_data = '0; invol_grant = 1'b0;
        time_in = '0; timesync_latch_in = 1'b0; shutdown_src = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_done",  {63'd0, cmd_done}, 64'd0);
        check("rst_data",  {32'd0, param_data}, 64'd0);
        check("rst_shut",  {63'd0, shutdown}, 64'd0);
        check("rst_req",   {63'd0, invol_req}, 64'd0);
        check("rst_ten",   {63'd0, time_out_en}, 64'd0);

        // version and feature words
        get_version("ver");

        // GET_TIME snapshot: time_in changes right after accept
        time_in = 64'h1_0000_0005;
        issue(C_TIME);
        time_in = 64'hDEAD_BEEF_0000_0000;
        word("time_w0", 32'd5);
        tick(); word("time_w1", 32'd1);
        tick(); done("time", R_TIME);

        // falling-edge latch at time_in = 1000
        timesync_latch_in = 1'b1;
        tick(); tick(); tick();
        time_in = 64'd1000;
        timesync_latch_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        time_in = 64'd1100;

        sync_time("sync1", 64'd500, 64'd1200, 1'b1, 64'd704);
        sync_time("sync2", 64'd500, 64'd1300, 1'b0, 64'd0);

        // command and fault in the same cycle: command first
        time_in = 64'h2_0000_0007;
        shutdown_src = 8'h04;
        issue(C_TIME);
        check("pri_req0", {63'd0, invol_req}, 64'd0);
        word("pri_w0", 32'd7);
        tick(); word("pri_w1", 32'd2);
        tick(); done("pri", R_TIME);
        check("pri_req1", {63'd0, invol_req}, 64'd0);
        tick();
        check("invol_req", {63'd0, invol_req}, 64'd1);
        tick();
        check("invol_hold", {63'd0, invol_req}, 64'd1);
        invol_grant = 1'b1;
        tick();
        invol_grant = 1'b0;
        check("invol_drop", {63'd0, invol_req}, 64'd0);
        word("invol_w", 32'd4);
        tick(); done("invol", R_SHUT);
        check("invol_shut",   {63'd0, shutdown}, 64'd1);
        check("invol_reason", {56'd0, shutdown_reason}, 64'h4);
        for (int i = 0; i < 4; i++) tick();
        check("no_more_invol", {63'd0, invol_req}, 64'd0);

        // unknown command still served after shutdown
        issue(8'h55);
        check("unk_done", {63'd0, cmd_done}, 64'd1);
        check("unk_wr",   {63'd0, param_write}, 64'd0);
        shutdown_src = '0;

        // reset in the middle of a GET_VERSION payload
        issue(C_VER);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_wr",   {63'd0, param_write}, 64'd0);
        check("mid_rst_data", {32'd0, param_data}, 64'd0);
        check("mid_rst_done", {63'd0, cmd_done}, 64'd0);
        check("mid_rst_shut", {63'd0, shutdown}, 64'd0);
        check("mid_rst_rsn",  {56'd0, shutdown_reason}, 64'd0);
        check("mid_rst_tout", time_out, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_wr", {63'd0, param_write}, 64'd0);
        get_version("ver2");

        // voluntary shutdown: no payload, reason untouched
        issue(C_SHUT);
        check("vshut_done", {63'd0, cmd_done}, 64'd1);
        check("vshut_wr",   {63'd0, param_write}, 64'd0);
        check("vshut_rsp",  {32'd0, param_data}, {32'd0, R_SHUT});
        check("vshut_shut", {63'd0, shutdown}, 64'd1);
        check("vshut_rsn",  {56'd0, shutdown_reason}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
